// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit.
//   - DefaultWidth : default datapath width
//   - alu_op_e     : opcode encoding (values 9..15 are illegal)
//   - alu_state_e  : control FSM states
//   - is_shift_op  : true for the multi-cycle shift opcodes
package alu_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpNot = 4'd5,
    OpSll = 4'd6,
    OpSrl = 4'd7,
    OpSra = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations (ADD, SUB, AND, OR, XOR, NOT).
// Ports:
//   a_i, b_i     : operands
//   op_i         : opcode
//   result_o     : result (0 for shift and illegal opcodes)
//   carry_o      : adder carry-out for ADD/SUB, 0 otherwise
//   err_o        : 1 for illegal opcodes (9..15)
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             err_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    err_o    = 1'b0;
    unique case (op_i)
      OpAdd: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OpSub: begin
        // Two's complement subtract: carry set means no borrow.
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OpAnd: result_o = a_i & b_i;
      OpOr:  result_o = a_i | b_i;
      OpXor: result_o = a_i ^ b_i;
      OpNot: result_o = ~a_i;
      // Shifts are handled by the sequential shifter in the top level.
      OpSll, OpSrl, OpSra: result_o = '0;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready request and response handshakes.
// Single-cycle ops complete one cycle after acceptance; shifts take one
// cycle per bit position on top of that.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only when idle)
//   input1, input2, shamt    : operands and shift amount
//   alu_control_signal       : opcode (see alu_pkg::alu_op_e)
//   rsp_valid / rsp_ready    : response handshake
//   out_from_ALU             : result, held until the response is taken
//   negative, zero, carry, err : result flags
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [4:0]       shamt,
  input  logic [3:0]       alu_control_signal,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out_from_ALU,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  alu_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [3:0]       sop_q, sop_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] comb_result;
  logic             comb_carry;
  logic             comb_err;

  logic [WIDTH-1:0] sh_next;
  logic             sh_out_bit;

  // Result load: one place updates result and derives negative/zero from it.
  logic             load_res;
  logic [WIDTH-1:0] res_val;
  logic             res_carry;
  logic             res_err;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .a_i      (input1),
    .b_i      (input2),
    .op_i     (alu_control_signal),
    .result_o (comb_result),
    .carry_o  (comb_carry),
    .err_o    (comb_err)
  );

  // One-bit shift step on the working register.
  always_comb begin
    sh_next    = sh_q;
    sh_out_bit = 1'b0;
    unique case (sop_q)
      OpSll: begin
        sh_next    = {sh_q[WIDTH-2:0], 1'b0};
        sh_out_bit = sh_q[WIDTH-1];
      end
      OpSrl: begin
        sh_next    = {1'b0, sh_q[WIDTH-1:1]};
        sh_out_bit = sh_q[0];
      end
      OpSra: begin
        sh_next    = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_out_bit = sh_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sop_d     = sop_q;
    load_res  = 1'b0;
    res_val   = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (is_shift_op(alu_control_signal)) begin
            sh_d  = input1;
            cnt_d = shamt;
            sop_d = alu_control_signal;
            if (shamt == 5'd0) begin
              // Nothing shifted out, so carry stays clear.
              load_res = 1'b1;
              res_val  = input1;
              state_d  = StDone;
            end else begin
              state_d = StShift;
            end
          end else begin
            load_res  = 1'b1;
            res_val   = comb_result;
            res_carry = comb_carry;
            res_err   = comb_err;
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          load_res  = 1'b1;
          res_val   = sh_next;
          res_carry = sh_out_bit;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    err_d    = err_q;
    if (load_res) begin
      result_d = res_val;
      neg_d    = res_val[WIDTH-1];
      zero_d   = (res_val == '0);
      carry_d  = res_carry;
      err_d    = res_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sh_q     <= '0;
      sop_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sop_q    <= sop_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StDone);
  assign out_from_ALU = result_q;
  assign negative     = neg_q;
  assign zero         = zero_q;
  assign carry        = carry_q;
  assign err          = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [4:0]  shamt;
  logic [3:0]  alu_control_signal;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] out_from_ALU;
  logic        negative;
  logic        zero;
  logic        carry;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  alu_exec_unit #(
    .WIDTH(32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .input1             (input1),
    .input2             (input2),
    .shamt              (shamt),
    .alu_control_signal (alu_control_signal),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .out_from_ALU       (out_from_ALU),
    .negative           (negative),
    .zero               (zero),
    .carry              (carry),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check result, flags, latency and handshake.
  // hold > 0 keeps rsp_ready low for that many cycles after rsp_valid rises.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] op,
                        input logic [31:0] er, input logic en, input logic ez,
                        input logic ec, input logic ee, input int elat, input int hold);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    check_eq({name, ".req_ready"}, 64'(req_ready), 64'd1);
    rsp_ready          = (hold == 0);
    req_valid          = 1'b1;
    input1             = a;
    input2             = b;
    shamt              = sh;
    alu_control_signal = op;
    @(posedge clk);
    #1;
    // Inputs are scrambled after acceptance and must not matter.
    req_valid          = 1'b0;
    input1             = ~a;
    input2             = ~b;
    shamt              = ~sh;
    alu_control_signal = ~op;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({name, ".latency"}, 64'(lat), 64'(elat));
    check_eq({name, ".result"}, 64'(out_from_ALU), 64'(er));
    check_eq({name, ".flags"}, 64'({negative, zero, carry, err}), 64'({en, ez, ec, ee}));
    if (hold > 0) begin
      held = out_from_ALU;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq({name, ".hold_valid"}, 64'(rsp_valid), 64'd1);
        check_eq({name, ".hold_result"}, 64'(out_from_ALU), 64'(held));
        check_eq({name, ".hold_ready"}, 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({name, ".rsp_done"}, 64'(rsp_valid), 64'd0);
    check_eq({name, ".idle_ready"}, 64'(req_ready), 64'd1);
    if (hold > 0) begin
      @(posedge clk);
      #1;
      check_eq({name, ".single_rsp"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    int seen;
    rst                = 1'b1;
    req_valid          = 1'b0;
    input1             = '0;
    input2             = '0;
    shamt              = '0;
    alu_control_signal = '0;
    rsp_ready          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.req_ready", 64'(req_ready), 64'd1);
    check_eq("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset.result", 64'(out_from_ALU), 64'd0);
    check_eq("reset.flags", 64'({negative, zero, carry, err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //      name       a             b             sh     op     result        n     z     c     e    lat hold
    run_op("add",     32'd32,       32'd53,       5'd0,  4'd0,  32'd85,       1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("sub_neg", 32'd32,       32'd53,       5'd0,  4'd1,  32'hFFFFFFEB, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("sub_eq",  32'd53,       32'd53,       5'd0,  4'd1,  32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
    run_op("add_ovf", 32'hFFFFFFFF, 32'd1,        5'd0,  4'd0,  32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
    run_op("and",     32'hF0F000FF, 32'h0FF00F0F, 5'd0,  4'd2,  32'h00F0000F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("or",      32'hF0F000FF, 32'h0FF00F0F, 5'd0,  4'd3,  32'hFFF00FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("not",     32'hF0F000FF, 32'h0FF00F0F, 5'd0,  4'd5,  32'h0F0FFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("sll1",    32'd302,      32'd0,        5'd1,  4'd6,  32'd604,      1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("sra4",    32'h80000000, 32'd0,        5'd4,  4'd8,  32'hF8000000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("sh0",     32'h00001234, 32'd0,        5'd0,  4'd6,  32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("srl_c",   32'h00000003, 32'd0,        5'd1,  4'd7,  32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
    run_op("sll_c",   32'hC0000000, 32'd0,        5'd2,  4'd6,  32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
    run_op("illegal", 32'h12345678, 32'h9ABCDEF0, 5'd3,  4'd12, 32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
    run_op("xor_bp",  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  4'd4,  32'hFF000FF0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3);

    // Reset in the middle of a long SRL: no response may ever appear.
    @(negedge clk);
    rsp_ready          = 1'b1;
    req_valid          = 1'b1;
    input1             = 32'hDEADBEEF;
    shamt              = 5'd31;
    alu_control_signal = 4'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid.req_ready", 64'(req_ready), 64'd1);
    check_eq("rstmid.result", 64'(out_from_ALU), 64'd0);
    check_eq("rstmid.flags", 64'({negative, zero, carry, err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check_eq("rstmid.no_rsp", 64'(seen), 64'd0);
    run_op("add_post", 32'd7, 32'd8, 5'd0, 4'd0, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
